// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, 1-cycle synchronous ROM fetch, stall hold
// buffer and a one-bubble squash after redirects, feeding the decoder.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int          ADDR_W   = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_q,
  output logic              fd_valid,
  output logic [31:0]       fd_instruction,
  output logic [31:0]       fd_pc,
  output logic [31:0]       fetch_count
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SQUASH = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_fd_pc;
  logic [31:0] r_hold_q;
  logic        r_hold_vld;
  logic [31:0] r_fetch_count;

  logic        w_run;

  function automatic logic [31:0] wrap_inc(input logic [31:0] v);
    return v + 32'd1;
  endfunction

  // Fetch address register -> ROM; fetched word lands on imem_q one cycle later
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_fd_pc       <= RESET_PC;
      r_hold_q      <= 32'd0;
      r_hold_vld    <= 1'b0;
      r_state       <= ST_BOOT;
      r_fetch_count <= 32'd0;
    end else if (redirect) begin
      r_pc       <= redirect_pc;
      r_hold_vld <= 1'b0;
      r_state    <= ST_SQUASH;
    end else if (!stall) begin
      r_pc       <= wrap_inc(r_pc);
      r_fd_pc    <= r_pc;
      r_hold_vld <= 1'b0;
      r_state    <= ST_RUN;
      if (r_state == ST_RUN) begin
        r_fetch_count <= wrap_inc(r_fetch_count);
      end
    end else if ((r_state == ST_RUN) && !r_hold_vld) begin
      // pc is frozen, so imem_q moves on to pc's word next cycle; capture the live one now
      r_hold_q   <= imem_q;
      r_hold_vld <= 1'b1;
    end
  end

  // Decode-facing outputs
  assign w_run          = (r_state == ST_RUN);
  assign imem_addr      = r_pc[ADDR_W-1:0];
  assign fd_valid       = w_run;
  assign fd_instruction = !w_run ? 32'd0 : (r_hold_vld ? r_hold_q : imem_q);
  assign fd_pc          = r_fd_pc;
  assign fetch_count    = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: synchronous ROM model plus an instruction-stream reference
// model, driven by directed scenarios followed by randomized control traffic.
module tb_fetch_stage;
  localparam int          ADDR_W   = 12;
  localparam logic [31:0] RESET_PC = 32'd0;

  logic              clock;
  logic              reset;
  logic              stall;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_q;
  logic              fd_valid;
  logic [31:0]       fd_instruction;
  logic [31:0]       fd_pc;
  logic [31:0]       fetch_count;

  fetch_stage #(.RESET_PC(RESET_PC), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_q(imem_q),
    .fd_valid(fd_valid), .fd_instruction(fd_instruction), .fd_pc(fd_pc),
    .fetch_count(fetch_count)
  );

  logic [31:0] rom [0:(1<<ADDR_W)-1];

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = 32'(i) + 32'd100;
  end

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) imem_q <= rom[imem_addr];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: which instruction the decoder should currently see
  bit          m_known  = 1'b0;
  bit          m_bubble = 1'b1;
  logic [31:0] m_cur    = '0;
  logic [31:0] m_next   = '0;
  logic [31:0] m_count  = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] exp_ins;
    logic [ADDR_W-1:0] cur_a, next_a;
    cur_a   = m_cur[ADDR_W-1:0];
    next_a  = m_next[ADDR_W-1:0];
    exp_ins = m_bubble ? 32'd0 : rom[cur_a];
    chk("fd_valid",    32'(fd_valid), 32'(!m_bubble));
    chk("fd_pc",       fd_pc, m_cur);
    chk("fd_instr",    fd_instruction, exp_ins);
    chk("imem_addr",   32'(imem_addr), 32'(next_a));
    chk("fetch_count", fetch_count, m_count);
  endtask

  task automatic model(input logic r, input logic s, input logic d, input logic [31:0] t);
    if (r) begin
      m_known  = 1'b1;
      m_bubble = 1'b1;
      m_cur    = RESET_PC;
      m_next   = RESET_PC;
      m_count  = '0;
    end else if (m_known) begin
      if (d) begin
        m_bubble = 1'b1;
        m_next   = t;
      end else if (!s) begin
        if (!m_bubble) m_count = m_count + 32'd1;
        m_cur    = m_next;
        m_next   = m_next + 32'd1;
        m_bubble = 1'b0;
      end
    end
  endtask

  task automatic step(input logic r, input logic s, input logic d, input logic [31:0] t);
    reset = r; stall = s; redirect = d; redirect_pc = t;
    @(negedge clock);
    if (m_known) check_outputs();
    @(posedge clock);
    model(r, s, d, t);
    #1;
  endtask

  task automatic run_to(input logic [31:0] pc);
    for (int i = 0; i < 64; i++) begin
      if (!m_bubble && m_cur == pc) break;
      step(1'b0, 1'b0, 1'b0, 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    @(posedge clock); #1;
    step(1'b1, 1'b1, 1'b1, 32'd77);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    // boot, stream, 3-cycle stall at pc 5, redirect to 40 at pc 7
    run_to(32'd5);
    repeat (3) step(1'b0, 1'b1, 1'b0, 32'd0);
    run_to(32'd7);
    step(1'b0, 1'b0, 1'b1, 32'd40);
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'd0);
    // redirect together with stall while a hold is active
    step(1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b1, 32'd200);
    repeat (2) step(1'b0, 1'b1, 1'b0, 32'd0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'd0);
    // reset mid-stall, then reset during squash
    repeat (2) step(1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'd300);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'd0);
    // pc wrap at 32'hFFFFFFFF
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    repeat (4) step(1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    repeat (2) step(1'b0, 1'b1, 1'b0, 32'd0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'd0);
    // randomized control traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, s, d;
      logic [31:0] t;
      r = ($urandom_range(0, 99) == 0);
      d = ($urandom_range(0, 9) == 0);
      s = ($urandom_range(0, 2) == 0);
      t = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                      : $urandom;
      step(r, s, d, t);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'd0: PC value loaded by reset.
REQ-002 Parameter ADDR_W, default 12: instruction-memory address width.
REQ-003 Clocking SHALL be one clock, `clock`; reset SHALL be `reset`, synchronous, active-high.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 stall  input  1  downstream decode cannot accept the current instruction.
REQ-007 redirect  input  1  taken branch/jump; load redirect_pc.
REQ-008 redirect_pc  input  32  redirect target PC.
REQ-009 imem_addr  output  ADDR_W  equals pc[ADDR_W-1:0], combinational from the pc register only.
REQ-010 imem_q  input  32  synchronous ROM data for the address presented in the previous cycle.
REQ-011 fd_valid  output  1  fd_instruction is a real instruction.
REQ-012 fd_instruction  output  32  instruction word to the decoder; 32'd0 (nop) when fd_valid=0.
REQ-013 fd_pc  output  32  PC of fd_instruction.
REQ-014 fetch_count  output  32  count of instructions accepted downstream.

Function
REQ-015 Registers: pc, fd_pc, hold_q[31:0], hold_valid, state, fetch_count.
REQ-016 States: BOOT, RUN, SQUASH.
  - BOOT and SQUASH SHALL be bubble states: fd_valid=0, fd_instruction=0.
  - RUN: fd_valid=1.
REQ-017 In RUN, fd_instruction SHALL be hold_q when hold_valid=1, else imem_q.
REQ-018 Priority SHALL be reset > redirect > stall.
REQ-019 On redirect (not reset):
  - pc<=redirect_pc.
  - hold_valid<=0.
  - state<=SQUASH, regardless of stall or current state.
REQ-020 With no redirect and stall=0:
  - pc<=pc+1, with 32-bit wrap (32'hFFFFFFFF -> 0).
  - fd_pc<=pc.
  - hold_valid<=0.
  - state<=RUN.
REQ-021 With no redirect and stall=1:
  - pc, fd_pc and state SHALL hold.
  - In RUN with hold_valid=0: hold_q<=imem_q and hold_valid<=1.
  - In BOOT/SQUASH: hold_valid is unchanged (0).
REQ-022 Fetch latency SHALL be 1 cycle: the instruction at PC P appears on fd_instruction the cycle after imem_addr=P.
REQ-023 The bubble after a redirect SHALL last exactly one unstalled cycle.
  - The instruction at redirect_pc SHALL be valid on the second cycle after the redirect cycle if stall=0.
REQ-024 fetch_count SHALL increment by 1, wrapping at 2^32, in every cycle where fd_valid=1, stall=0 and redirect=0.
REQ-025 A stall lasting N cycles SHALL present the same fd_instruction/fd_pc for N+1 cycles with no instruction lost or duplicated.

Reset
REQ-026 On reset=1 at a clock edge:
  - pc<=RESET_PC, fd_pc<=RESET_PC.
  - hold_q<=0, hold_valid<=0.
  - state<=BOOT.
  - fetch_count<=0.
REQ-027 Reset SHALL override redirect and stall in the same cycle and abort any in-progress stall hold or squash.
REQ-028 In the first cycle after reset: fd_valid=0, fd_instruction=0, imem_addr=RESET_PC[ADDR_W-1:0].

Verification
REQ-029 Reset release with RESET_PC=0, ROM[n]=n+100, stall=0 -> cycle 0 bubble; then fd_pc=0,1,2 with instructions 100,101,102 on consecutive cycles, fetch_count=3.
REQ-030 stall=1 for 3 cycles while fd_pc=5 -> fd_instruction=105 and fd_pc=5 held for 4 cycles; next cycle fd_pc=6, 106; fetch_count increments only once for PC 5.
REQ-031 redirect=1 with redirect_pc=40 while fd_pc=7 -> next cycle fd_valid=0, fd_instruction=0; following cycle fd_pc=40, 140.
REQ-032 redirect=1 and stall=1 in the same cycle with a hold active -> hold_valid cleared, SQUASH entered, pc=redirect_pc; bubble persists while stall=1; then target instruction appears.
REQ-033 reset=1 during SQUASH or mid-stall -> all registers at reset values next cycle; BOOT bubble; fetch resumes at RESET_PC.
REQ-034 redirect_pc=32'hFFFFFFFF, ADDR_W=12 -> fd_pc=32'hFFFFFFFF, then fd_pc=0 (imem_addr=12'h000) with no spurious bubble.
